jpeg_dma_ctrl: RTL

Sequencing controller for the JPEG accelerator's DMA read path. Issues Wishbone classic read cycles at the addresses produced by the macroblock address generator and steps that generator. Packs each 8x8-pixel block (16 words) into the block buffer, then hands the block to the DCT/quantiser consumer with a ready/ack handshake. It sits between the JPEG control registers, the address generator, the Wishbone master port and the input block buffer.

---
 rtl/jpeg_dma_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/jpeg_dma_ctrl.sv
// jpeg_dma_ctrl: DMA read sequencer for the JPEG accelerator input path.
// Issues Wishbone classic reads at the address generator's addresses and
// packs 16-word blocks into the block buffer. It then hands each block to
// the DCT consumer with a ready/ack handshake.
// Optional feature macro: JPEG_DMA_TIMEOUT_EN adds an ack watchdog that
// forces ERROR after TIMEOUT_CYCLES stalled READ cycles.
module jpeg_dma_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        ag_resetaddr_o,
  output logic        ag_incaddr_o,
  input  logic [31:0] ag_address_i,
  input  logic        ag_endblock_i,
  input  logic        ag_endframe_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        buf_we_o,
  output logic [3:0]  buf_addr_o,
  output logic [31:0] buf_wdata_o,
  output logic        blk_ready_o,
  input  logic        blk_ack_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    READ    = 3'd2,
    HANDOFF = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        take_s;      // a data beat is accepted this cycle
  logic        timeout_s;   // watchdog expiry this cycle
  logic [3:0]  cnt_r;       // word index within the current block
  logic        last_r;      // current block is the last of the frame
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic        resetaddr_r;
  logic        stb_r;
  logic        ready_r;

`ifdef JPEG_DMA_TIMEOUT_EN
  logic [7:0]  wd_r;

  // Watchdog expires on the cycle that would bring the stall count to the limit.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r == READ) && (wd_r == 8'(TIMEOUT_CYCLES - 32'd1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Count consecutive READ cycles with the strobe up and no response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_r <= 8'd0;
    end else if ((state_r == READ) && (state_s == READ) && !wb_ack_i) begin
      wd_r <= wd_r + 8'd1;
    end else begin
      wd_r <= 8'd0;
    end
  end
`else
  // Without the watchdog the limit has no effect and READ waits forever.
  localparam bit WD_PRESENT = 1'b0;
  assign timeout_s = WD_PRESENT && (TIMEOUT_CYCLES == 32'd0);
`endif

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) state_s = INIT;
        else         state_s = IDLE;
      end
      INIT: begin
        state_s = READ;
      end
      READ: begin
        if (wb_err_i) begin
          state_s = ERROR;             // error beats a simultaneous ack
        end else if (wb_ack_i) begin
          take_s = 1'b1;
          if (ag_endblock_i) state_s = HANDOFF;
          else               state_s = READ;
        end else if (timeout_s) begin
          state_s = ERROR;
        end else begin
          state_s = READ;
        end
      end
      HANDOFF: begin
        if (blk_ack_i) state_s = last_r ? DONE : READ;
        else           state_s = HANDOFF;
      end
      DONE: begin
        state_s = IDLE;
      end
      ERROR: begin
        if (start_i) state_s = INIT;
        else         state_s = ERROR;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (abort_i) begin
      state_s = IDLE;
      take_s  = 1'b0;
    end else begin
      take_s  = take_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Registered control outputs, decoded from the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      resetaddr_r <= 1'b0;
      stb_r       <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      busy_r      <= (state_s == INIT) || (state_s == READ) || (state_s == HANDOFF);
      done_r      <= (state_s == DONE);
      resetaddr_r <= (state_s == INIT);
      stb_r       <= (state_s == READ);
      ready_r     <= (state_s == HANDOFF);
    end
  end

  // Sticky error flag: set on entering ERROR, cleared only by an accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                err_r <= 1'b0;
    else if (state_s == ERROR)  err_r <= 1'b1;
    else if (state_s == INIT)   err_r <= 1'b0;
    else                        err_r <= err_r;
  end

  // Word counter and last-block flag; the end-of-block beat always
  // re-aligns the counter to 0, even if the generator disagreed with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r  <= 4'd0;
      last_r <= 1'b0;
    end else if (abort_i || (state_s == INIT)) begin
      cnt_r  <= 4'd0;
      last_r <= 1'b0;
    end else if (take_s && ag_endblock_i) begin
      cnt_r  <= 4'd0;
      last_r <= ag_endframe_i;
    end else if (take_s) begin
      cnt_r  <= cnt_r + 4'd1;
      last_r <= last_r;
    end else begin
      cnt_r  <= cnt_r;
      last_r <= last_r;
    end
  end

  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign err_o          = err_r;
  assign ag_resetaddr_o = resetaddr_r;
  assign blk_ready_o    = ready_r;
  assign wb_cyc_o       = stb_r;
  assign wb_stb_o       = stb_r;
  // The generator moves the cycle after each ack, so the address must follow it live.
  assign wb_adr_o       = stb_r ? ag_address_i : 32'd0;
  assign wb_we_o        = 1'b0;
  assign wb_sel_o       = 4'hF;
  assign ag_incaddr_o   = take_s;
  assign buf_we_o       = take_s;
  assign buf_addr_o     = take_s ? cnt_r : 4'd0;
  assign buf_wdata_o    = take_s ? wb_dat_i : 32'd0;

endmodule
